// File: rtl/probe_trigger_multi_if.sv
// Probe command / uplink bus shared by the trigger probe and the host side.
// The master drives commands, triggers and ack; the slave reports words and status.
interface probe_trigger_multi_if #(
  parameter int NumTriggers = 4
);
  logic                   cmd_en;
  logic [18:0]            cmd;
  logic [NumTriggers-1:0] trigger;
  logic [31:0]            data_up;
  logic                   data_valid;
  logic                   ack;
  logic                   delay;
  logic [NumTriggers-1:0] overflow;

  modport master (
    output cmd_en, cmd, trigger, ack,
    input  data_up, data_valid, delay, overflow
  );

  modport slave (
    input  cmd_en, cmd, trigger, ack,
    output data_up, data_valid, delay, overflow
  );
endinterface

// File: rtl/probe_trigger_multi.sv
// Multi-channel trigger probe: per-channel enable counts, sticky overflow,
// round-robin event reporting over the serial-probe uplink.
module probe_trigger_multi #(
  parameter logic [15:0] TriggerId = 16'h0000,
  parameter int NumTriggers = 4,
  parameter logic [NumTriggers-1:0] TrigEdge = '0,
  parameter int NumWords = 1,
  parameter logic [NumWords*16-1:0] CaptureIds = {NumWords{16'hFFFF}},
  parameter int CWidth = 1
) (
  input logic clk,
  input logic rst,
  probe_trigger_multi_if.slave bus
);

  localparam int PW = (NumTriggers > 1) ? $clog2(NumTriggers) : 1;

  localparam logic [2:0] OpDisable = 3'd1;
  localparam logic [2:0] OpEnable  = 3'd2;
  localparam logic [2:0] OpTrigAck = 3'd3;
  localparam logic [2:0] OpClear   = 3'd4;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]             state;
  logic [7:0]             count [NumTriggers];
  logic [NumTriggers-1:0] enabled;
  logic [NumTriggers-1:0] pending;
  logic [NumTriggers-1:0] prev;
  logic [NumTriggers-1:0] fire;
  logic [NumTriggers-1:0] hit;
  logic [NumTriggers-1:0] clr_ovf;
  logic [NumTriggers-1:0] ready;
  logic [NumTriggers-1:0] done_clr;
  logic [PW-1:0]          rr_ptr;
  logic [PW-1:0]          sel;
  logic [PW-1:0]          pick;
  logic                   found;
  logic [CWidth-1:0]      word_count;
  logic [NumWords*16-1:0] report_ids;
  logic                   send_disable;
  logic                   msg_end;
  logic [15:0]            sel_id;
  logic [15:0]            pick_id;

  function automatic logic [PW-1:0] wrap(input int v);
    return PW'(v % NumTriggers);
  endfunction

  assign fire = (bus.trigger & ~prev & TrigEdge)
              | (bus.trigger & ~TrigEdge);
  assign ready = enabled & pending;
  assign bus.delay = |ready;
  assign sel_id = TriggerId + 16'(sel);
  assign pick_id = TriggerId + 16'(pick);
  assign msg_end = (state == SEND) && bus.ack
                && (word_count == '0) && !send_disable;

  always_comb begin
    hit = '0;
    clr_ovf = '0;
    done_clr = '0;
    for (int i = 0; i < NumTriggers; i++) begin
      hit[i] = bus.cmd_en
            && (bus.cmd[18:3] == TriggerId + 16'(i));
      clr_ovf[i] = hit[i] && (bus.cmd[2:0] == OpClear);
      done_clr[i] = msg_end && (sel == PW'(i));
    end
  end

  // Descending scan so the nearest channel at or after rr_ptr wins.
  always_comb begin
    found = 1'b0;
    pick = rr_ptr;
    for (int k = NumTriggers - 1; k >= 0; k--) begin
      if (ready[wrap(int'(rr_ptr) + k)]) begin
        found = 1'b1;
        pick = wrap(int'(rr_ptr) + k);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enabled <= '0;
      pending <= '0;
      prev <= '0;
      bus.overflow <= '0;
      for (int i = 0; i < NumTriggers; i++) count[i] <= '0;
    end else begin
      prev <= bus.trigger;
      pending <= fire | (pending & enabled & ~done_clr);
      bus.overflow <= (bus.overflow & ~clr_ovf)
                    | (fire & pending & enabled & ~done_clr);
      for (int i = 0; i < NumTriggers; i++) begin
        if (hit[i]) begin
          case (bus.cmd[2:0])
            OpDisable: begin
              count[i] <= '0;
              enabled[i] <= 1'b0;
            end
            OpEnable: begin
              if (count[i] != 8'hFF) count[i] <= count[i] + 8'd1;
              enabled[i] <= 1'b1;
            end
            OpTrigAck: begin
              count[i] <= count[i] - 8'd1;
              enabled[i] <= (count[i] != 8'd1);
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sel <= '0;
      rr_ptr <= '0;
      word_count <= '0;
      report_ids <= CaptureIds;
      send_disable <= 1'b0;
      bus.data_up <= '0;
      bus.data_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            sel <= pick;
            word_count <= CWidth'(NumWords);
            report_ids <= CaptureIds;
            send_disable <= (count[pick] == 8'd1);
            bus.data_up <= {pick_id, 13'h1FFF, 3'd3};
            bus.data_valid <= 1'b1;
            state <= SEND;
          end
        end
        SEND: begin
          if (bus.ack) begin
            if (word_count != '0) begin
              bus.data_up <= {report_ids[15:0], 13'h1FFF, 3'd3};
              word_count <= word_count - 1'b1;
              report_ids <= report_ids >> 16;
            end else if (send_disable) begin
              bus.data_up <= {sel_id, 13'h1FFF, 3'd1};
              send_disable <= 1'b0;
            end else begin
              state <= IDLE;
              bus.data_valid <= 1'b0;
              rr_ptr <= (sel == PW'(NumTriggers - 1)) ? '0 : sel + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_probe_trigger_multi.sv
// Bench for probe_trigger_multi: message-queue reference model checked
// every cycle, plus literal uplink word sequences for directed scenarios.
module tb_probe_trigger_multi;

  localparam logic [15:0] TID = 16'h0010;
  localparam logic [3:0] EDGE = 4'b0010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit go = 0;
  int errors = 0;
  int checks = 0;

  probe_trigger_multi_if #(.NumTriggers(4)) bus ();

  probe_trigger_multi #(
    .TriggerId(TID),
    .NumTriggers(4),
    .TrigEdge(EDGE),
    .NumWords(2),
    .CaptureIds({16'h0021, 16'h0020}),
    .CWidth(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: whole messages are queued at start and popped per ack.
  logic [15:0] cap [2] = '{16'h0020, 16'h0021};
  bit m_en [4];
  bit m_pend [4];
  bit m_ovf [4];
  bit m_prev [4];
  logic [7:0] m_cnt [4];
  int m_rr;
  int m_sel;
  bit m_busy;
  logic [31:0] m_q [$];
  bit f [4];
  bit np [4];
  bit ovset [4];
  bit done;
  bit clr;
  int start;
  int c;
  int ch;
  logic [15:0] sid;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0;
      m_rr = 0;
      m_sel = 0;
      m_q.delete();
      for (int i = 0; i < 4; i++) begin
        m_en[i] = 0; m_pend[i] = 0; m_ovf[i] = 0;
        m_prev[i] = 0; m_cnt[i] = 0;
      end
    end else begin
      done = 0;
      start = -1;
      for (int i = 0; i < 4; i++)
        f[i] = EDGE[i] ? (bus.trigger[i] && !m_prev[i]) : bus.trigger[i];
      if (m_busy) begin
        if (bus.ack) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) done = 1;
        end
      end else begin
        for (int k = 3; k >= 0; k--) begin
          c = (m_rr + k) % 4;
          if (m_en[c] && m_pend[c]) start = c;
        end
      end
      if (start >= 0) begin
        sid = TID + 16'(start);
        m_q.push_back({sid, 13'h1FFF, 3'd3});
        for (int w = 0; w < 2; w++) m_q.push_back({cap[w], 13'h1FFF, 3'd3});
        if (m_cnt[start] == 8'd1) m_q.push_back({sid, 13'h1FFF, 3'd1});
        m_sel = start;
        m_busy = 1;
      end
      for (int i = 0; i < 4; i++) begin
        clr = done && (i == m_sel);
        ovset[i] = f[i] && m_pend[i] && m_en[i] && !clr;
        np[i] = f[i] || (m_pend[i] && m_en[i] && !clr);
      end
      if (done) begin
        m_busy = 0;
        m_rr = (m_sel + 1) % 4;
      end
      if (bus.cmd_en) begin
        ch = int'(bus.cmd[18:3]) - int'(TID);
        if (ch >= 0 && ch < 4) begin
          case (bus.cmd[2:0])
            3'd1: begin m_cnt[ch] = 0; m_en[ch] = 0; end
            3'd2: begin
              if (m_cnt[ch] != 8'hFF) m_cnt[ch] = m_cnt[ch] + 8'd1;
              m_en[ch] = 1;
            end
            3'd3: begin
              m_en[ch] = (m_cnt[ch] != 8'd1);
              m_cnt[ch] = m_cnt[ch] - 8'd1;
            end
            3'd4: m_ovf[ch] = 0;
            default: ;
          endcase
        end
      end
      for (int i = 0; i < 4; i++) begin
        m_pend[i] = np[i];
        if (ovset[i]) m_ovf[i] = 1;
        m_prev[i] = bus.trigger[i];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit any_ready();
    bit r = 0;
    for (int i = 0; i < 4; i++) r |= m_en[i] & m_pend[i];
    return r;
  endfunction

  function automatic bit any_pend();
    bit r = 0;
    for (int i = 0; i < 4; i++) r |= m_pend[i];
    return r;
  endfunction

  always @(negedge clk) begin
    if (go && !rst) begin
      chk("valid", 32'(bus.data_valid), 32'(m_busy));
      if (m_busy) chk("data_up", bus.data_up, m_q[0]);
      chk("delay", 32'(bus.delay), 32'(any_ready()));
      chk("overflow", 32'(bus.overflow),
          32'({m_ovf[3], m_ovf[2], m_ovf[1], m_ovf[0]}));
    end
  end

  logic [31:0] log_q [$];
  logic [31:0] exp_q [$];

  always @(posedge clk)
    if (go && !rst && bus.data_valid && bus.ack) log_q.push_back(bus.data_up);

  task automatic chk_log(input string nm);
    chk({nm, "_len"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk(nm, log_q[i], exp_q[i]);
    log_q.delete();
  endtask

  task automatic send_cmd(input int chn, input logic [2:0] op);
    bus.cmd_en = 1'b1;
    bus.cmd = {TID + 16'(chn), op};
    @(negedge clk);
    bus.cmd_en = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] m);
    bus.trigger = m;
    @(negedge clk);
    bus.trigger = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    repeat (2) @(negedge clk);
    while ((m_busy || any_pend() || bus.data_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: got timeout expected idle");
    end
  endtask

  initial begin
    int n;
    bus.cmd_en = 1'b0;
    bus.cmd = '0;
    bus.trigger = '0;
    bus.ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_up", bus.data_up, 32'h0);
    chk("rst_valid", 32'(bus.data_valid), 32'h0);
    chk("rst_delay", 32'(bus.delay), 32'h0);
    chk("rst_ovf", 32'(bus.overflow), 32'h0);
    #2 rst = 1'b0;
    @(negedge clk);
    go = 1;

    // Single trigger, count 1: header, two ids, then disable word.
    bus.ack = 1'b1;
    send_cmd(0, 3'd2);
    pulse(4'b0001);
    wait_idle();
    exp_q = '{32'h0010FFFB, 32'h0020FFFB, 32'h0021FFFB, 32'h0010FFF9};
    chk_log("t1");

    // Count 2: no disable word; TRIGGERED-ACK leaves count 1, still enabled.
    send_cmd(0, 3'd1);
    send_cmd(0, 3'd2);
    send_cmd(0, 3'd2);
    pulse(4'b0001);
    wait_idle();
    exp_q = '{32'h0010FFFB, 32'h0020FFFB, 32'h0021FFFB};
    chk_log("t2a");
    send_cmd(0, 3'd3);
    pulse(4'b0001);
    wait_idle();
    exp_q = '{32'h0010FFFB, 32'h0020FFFB, 32'h0021FFFB, 32'h0010FFF9};
    chk_log("t2b");

    // Round robin from rr_ptr=2.
    for (int i = 1; i < 4; i++) begin
      send_cmd(i, 3'd2);
      send_cmd(i, 3'd2);
    end
    pulse(4'b0010);
    wait_idle();
    log_q.delete();
    pulse(4'b1110);
    wait_idle();
    exp_q = '{32'h0012FFFB, 32'h0020FFFB, 32'h0021FFFB,
              32'h0013FFFB, 32'h0020FFFB, 32'h0021FFFB,
              32'h0011FFFB, 32'h0020FFFB, 32'h0021FFFB};
    chk_log("t3");

    // Level mode held high with the uplink stalled -> overflow, then clear.
    bus.ack = 1'b0;
    bus.trigger = 4'b0001;
    repeat (5) @(negedge clk);
    bus.trigger = '0;
    chk("t4_ovf_set", 32'(bus.overflow[0]), 32'h1);
    send_cmd(0, 3'd4);
    chk("t4_ovf_clr", 32'(bus.overflow[0]), 32'h0);
    bus.ack = 1'b1;
    wait_idle();
    exp_q = '{32'h0010FFFB, 32'h0020FFFB, 32'h0021FFFB, 32'h0010FFF9};
    chk_log("t4a");
    bus.ack = 1'b0;
    bus.trigger = 4'b0010;
    repeat (5) @(negedge clk);
    bus.trigger = '0;
    bus.ack = 1'b1;
    wait_idle();
    chk("t4_edge_ovf", 32'(bus.overflow[1]), 32'h0);
    exp_q = '{32'h0011FFFB, 32'h0020FFFB, 32'h0021FFFB};
    chk_log("t4b");

    // Disabled channel trigger is dropped and not replayed on enable.
    send_cmd(2, 3'd1);
    pulse(4'b0100);
    repeat (3) @(negedge clk);
    send_cmd(2, 3'd2);
    repeat (5) @(negedge clk);
    chk("t5_valid", 32'(bus.data_valid), 32'h0);
    exp_q.delete();
    chk_log("t5a");

    // Enable saturates at 8'hFF: 254 acks then bring count to exactly 1.
    for (int i = 0; i < 256; i++) send_cmd(3, 3'd2);
    for (int i = 0; i < 254; i++) send_cmd(3, 3'd3);
    pulse(4'b1000);
    wait_idle();
    exp_q = '{32'h0013FFFB, 32'h0020FFFB, 32'h0021FFFB, 32'h0013FFF9};
    chk_log("t5b");

    // Reset during the second word of a message.
    pulse(4'b0001);
    n = 0;
    while (!bus.data_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL t6_start: got no valid expected valid");
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_valid", 32'(bus.data_valid), 32'h0);
    chk("t6_up", bus.data_up, 32'h0);
    chk("t6_delay", 32'(bus.delay), 32'h0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    log_q.delete();
    repeat (5) @(negedge clk);
    chk("t6_idle", 32'(bus.data_valid), 32'h0);
    send_cmd(0, 3'd2);
    pulse(4'b0001);
    wait_idle();
    exp_q = '{32'h0010FFFB, 32'h0020FFFB, 32'h0021FFFB, 32'h0010FFF9};
    chk_log("t6");

    go = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
